// File: rtl/ticket_pkg.sv
// Shared types for the ticket pool manager: FSM states, request ops and
// response error codes.
package ticket_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic OP_BUY    = 1'b0;
  localparam logic OP_CANCEL = 1'b1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_STOCK   = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

endpackage

// File: rtl/ticket_counter.sv
// One category's ticket count: load to capacity, subtract only when enough
// stock remains, add only when the result stays within capacity.
module ticket_counter #(
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 32,
  parameter int QTY_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             sub_en,
  input  logic             add_en,
  input  logic [QTY_W-1:0] qty,
  output logic [CNT_W-1:0] count,
  output logic             can_sub,
  output logic             can_add,
  output logic             is_zero
);

  localparam logic [CNT_W:0] CAP_EXT = (CNT_W+1)'(CAPACITY);

  logic [CNT_W:0] qty_ext;
  logic [CNT_W:0] diff;
  logic [CNT_W:0] sum;

  // One guard bit keeps both the borrow and the overflow visible.
  assign qty_ext = (CNT_W+1)'(qty);
  assign diff    = {1'b0, count} - qty_ext;
  assign sum     = {1'b0, count} + qty_ext;
  assign can_sub = ({1'b0, count} >= qty_ext);
  assign can_add = (sum <= CAP_EXT);
  assign is_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(CAPACITY);
    end else if (sub_en && can_sub) begin
      count <= diff[CNT_W-1:0];
    end else if (add_en && can_add) begin
      count <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/ticket_pool_manager.sv
// Ticket pool manager: per-category stock with BUY/CANCEL requests, one
// registered response per accepted request, and a saturating net-sold total.
module ticket_pool_manager
  import ticket_pkg::*;
#(
  parameter int NUM_CAT  = 4,
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 32,
  parameter int QTY_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sale_open,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [$clog2(NUM_CAT)-1:0] req_cat,
  input  logic [QTY_W-1:0]           req_qty,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_ok,
  output logic [1:0]                 resp_err,
  output logic [NUM_CAT*CNT_W-1:0]   avail,
  output logic [NUM_CAT-1:0]         sold_out,
  output logic [15:0]                sold_total
);

  localparam int IDX_W = $clog2(NUM_CAT);

  if (CAPACITY >= 2**CNT_W) begin : g_cap_check
    $error("CAPACITY must be below 2**CNT_W");
  end

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   init_idx;
  logic [NUM_CAT-1:0] load_en, sub_en, add_en;
  logic [NUM_CAT-1:0] can_sub, can_add, is_zero;
  logic [CNT_W-1:0]   count [NUM_CAT];

  logic       accept;
  logic       legal;
  logic       dec_ok;
  logic [1:0] dec_err;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [QTY_W-1:0] q);
    logic [16:0] s;
    s = {1'b0, a} + 17'(q);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] floor_sub16(input logic [15:0] a, input logic [QTY_W-1:0] q);
    return (a >= 16'(q)) ? (a - 16'(q)) : 16'd0;
  endfunction

  for (genvar k = 0; k < NUM_CAT; k++) begin : g_cat
    ticket_counter #(
      .CNT_W   (CNT_W),
      .CAPACITY(CAPACITY),
      .QTY_W   (QTY_W)
    ) u_counter (
      .clk    (clk),
      .reset  (reset),
      .load   (load_en[k]),
      .sub_en (sub_en[k]),
      .add_en (add_en[k]),
      .qty    (req_qty),
      .count  (count[k]),
      .can_sub(can_sub[k]),
      .can_add(can_add[k]),
      .is_zero(is_zero[k])
    );
    assign avail[k*CNT_W +: CNT_W] = count[k];
  end

  assign sold_out   = is_zero;
  assign resp_valid = (state == ST_RESP);
  assign accept     = (state == ST_READY) && req_valid;

  // Decision: illegal outranks stock/overflow; a CANCEL ignores sale_open.
  always_comb begin
    legal   = (int'(req_cat) < NUM_CAT) && (req_qty != '0) &&
              ((req_op == OP_CANCEL) || sale_open);
    dec_ok  = 1'b0;
    dec_err = ERR_ILLEGAL;
    if (legal) begin
      if (req_op == OP_BUY) begin
        dec_ok  = can_sub[req_cat];
        dec_err = dec_ok ? ERR_NONE : ERR_STOCK;
      end else begin
        dec_ok  = can_add[req_cat];
        dec_err = dec_ok ? ERR_NONE : ERR_OVF;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    load_en   = '0;
    sub_en    = '0;
    add_en    = '0;
    case (state)
      ST_INIT: begin
        load_en[init_idx] = 1'b1;
        if (init_idx == IDX_W'(NUM_CAT-1)) state_nxt = ST_READY;
      end
      ST_READY: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = ST_RESP;
          if (dec_ok) begin
            if (req_op == OP_BUY) sub_en[req_cat] = 1'b1;
            else                  add_en[req_cat] = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_READY;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      init_idx   <= '0;
      sold_total <= '0;
      resp_ok    <= 1'b0;
      resp_err   <= ERR_NONE;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_idx <= init_idx + 1'b1;
      if (accept) begin
        resp_ok  <= dec_ok;
        resp_err <= dec_err;
        if (dec_ok) begin
          if (req_op == OP_BUY) sold_total <= sat_add16(sold_total, req_qty);
          else                  sold_total <= floor_sub16(sold_total, req_qty);
        end
      end
    end
  end

endmodule

// File: tb/tb_ticket_pool_manager.sv
// Randomized self-checking bench for ticket_pool_manager against a plain
// array-based model of the stock and sold-total rules.
module tb_ticket_pool_manager;

  localparam int NUM_CAT  = 4;
  localparam int CNT_W    = 8;
  localparam int CAPACITY = 32;
  localparam int QTY_W    = 3;
  localparam int CAT_W    = $clog2(NUM_CAT);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     sale_open;
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_op;
  logic [CAT_W-1:0]         req_cat;
  logic [QTY_W-1:0]         req_qty;
  logic                     resp_valid;
  logic                     resp_ready;
  logic                     resp_ok;
  logic [1:0]               resp_err;
  logic [NUM_CAT*CNT_W-1:0] avail;
  logic [NUM_CAT-1:0]       sold_out;
  logic [15:0]              sold_total;

  ticket_pool_manager #(
    .NUM_CAT (NUM_CAT),
    .CNT_W   (CNT_W),
    .CAPACITY(CAPACITY),
    .QTY_W   (QTY_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sale_open (sale_open),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_cat   (req_cat),
    .req_qty   (req_qty),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_ok   (resp_ok),
    .resp_err  (resp_err),
    .avail     (avail),
    .sold_out  (sold_out),
    .sold_total(sold_total)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcnt [NUM_CAT];
  int msold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < NUM_CAT; k++) begin
      chk($sformatf("%s avail%0d", tag, k), 32'(avail[k*CNT_W +: CNT_W]), mcnt[k]);
      chk($sformatf("%s sold_out%0d", tag, k), 32'(sold_out[k]), 32'(mcnt[k] == 0));
    end
    chk($sformatf("%s sold_total", tag), 32'(sold_total), msold);
  endtask

  // Stock rules expressed directly on integers.
  task automatic model(input bit op, input int cat, input int qty, input bit open,
                       output bit ok, output int err);
    ok  = 1'b0;
    err = 3;
    if (cat >= NUM_CAT || qty == 0 || (op == 1'b0 && !open)) begin
      err = 3;
    end else if (op == 1'b0) begin
      if (qty > mcnt[cat]) err = 1;
      else begin
        ok = 1'b1; err = 0;
        mcnt[cat] -= qty;
        msold = (msold + qty > 65535) ? 65535 : msold + qty;
      end
    end else begin
      if (mcnt[cat] + qty > CAPACITY) err = 2;
      else begin
        ok = 1'b1; err = 0;
        mcnt[cat] += qty;
        msold = (msold >= qty) ? msold - qty : 0;
      end
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input bit op, input int cat, input int qty, input bit open,
                     input int hold, input string tag);
    bit exp_ok;
    int exp_err;
    wait_ready();
    req_op    = op;
    req_cat   = CAT_W'(cat);
    req_qty   = QTY_W'(qty);
    sale_open = open;
    req_valid = 1'b1;
    model(op, cat, qty, open, exp_ok, exp_err);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " req_ready_busy"}, 32'(req_ready), 32'd0);
    chk({tag, " resp_ok"}, 32'(resp_ok), 32'(exp_ok));
    chk({tag, " resp_err"}, 32'(resp_err), exp_err);
    for (int i = 0; i < hold; i++) begin
      sale_open = 1'($urandom);
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " hold_ok"}, 32'(resp_ok), 32'(exp_ok));
      chk({tag, " hold_err"}, 32'(resp_err), exp_err);
      chk({tag, " hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, " resp_done"}, 32'(resp_valid), 32'd0);
    check_state(tag);
  endtask

  task automatic count_init(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " init_cycles"}, n, 32'd4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit op;
    reset      = 1'b1;
    sale_open  = 1'b1;
    req_valid  = 1'b1;
    req_op     = 1'b0;
    req_cat    = '0;
    req_qty    = '0;
    resp_ready = 1'b0;
    for (int k = 0; k < NUM_CAT; k++) mcnt[k] = 0;
    msold = 0;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);

    // Release reset with an (illegal) request already waiting.
    reset = 1'b0;
    count_init("boot");
    for (int k = 0; k < NUM_CAT; k++) mcnt[k] = CAPACITY;
    check_state("boot");
    txn(1'b0, 0, 0, 1'b1, 0, "sweep");

    // Drain category 0.
    for (int i = 0; i < 4; i++) txn(1'b0, 0, 7, 1'b1, 0, "drain7");
    txn(1'b0, 0, 4, 1'b1, 0, "drain4");
    chk("drained sold_out0", 32'(sold_out[0]), 32'd1);
    chk("drained sold_total", 32'(sold_total), 32'd32);
    txn(1'b0, 0, 1, 1'b1, 0, "empty_buy");

    // Cancel bounds on a full category.
    txn(1'b1, 1, 1, 1'b1, 0, "cancel_full");
    txn(1'b0, 1, 5, 1'b1, 0, "buy5");
    txn(1'b1, 1, 5, 1'b1, 0, "cancel5");
    chk("cancel5 sold_total", 32'(sold_total), 32'd32);

    // Illegal requests and closed-window cancel.
    txn(1'b0, 2, 3, 1'b0, 0, "buy_closed");
    txn(1'b0, 2, 0, 1'b1, 0, "qty0");
    txn(1'b1, 0, 3, 1'b0, 0, "cancel_closed");

    // Backpressure.
    txn(1'b0, 3, 2, 1'b1, 5, "backpressure");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1;
      txn(op, $urandom_range(0, NUM_CAT-1), $urandom_range(0, 7),
          $urandom_range(0, 9) != 0, $urandom_range(0, 3), "rand");
    end

    // Reset in the middle of a pending response.
    wait_ready();
    req_op = 1'b0; req_cat = 2'd2; req_qty = 3'd1; sale_open = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midresp resp_valid", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NUM_CAT; k++) mcnt[k] = 0;
    msold = 0;
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst resp_ok", 32'(resp_ok), 32'd0);
    chk("midrst resp_err", 32'(resp_err), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    check_state("midrst");
    reset = 1'b0;
    count_init("reinit");
    for (int k = 0; k < NUM_CAT; k++) mcnt[k] = CAPACITY;
    check_state("reinit");

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1;
      txn(op, $urandom_range(0, NUM_CAT-1), $urandom_range(0, 7),
          $urandom_range(0, 9) != 0, $urandom_range(0, 2), "rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ticket_pool_manager.md
TICKET_POOL_MANAGER -- requirements
Module: ticket_pool_manager

Interface
REQ-001 The block SHALL expose these parameters: NUM_CAT, default 4, number of ticket categories; CNT_W, default 8, counter width; CAPACITY, default 32, initial tickets per category; QTY_W, default 3, request-quantity width.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 The port sale_open SHALL be an input, 1 bit wide: sales window open; buys rejected when 0.
REQ-005 The port req_valid SHALL be an input, 1 bit wide: request present.
REQ-006 The port req_ready SHALL be an output, 1 bit wide: block can accept a request.
REQ-007 The port req_op SHALL be an input, 1 bit wide: 0 = BUY, 1 = CANCEL.
REQ-008 The port req_cat SHALL be an input, $clog2(NUM_CAT) bits wide: category index.
REQ-009 The port req_qty SHALL be an input, QTY_W bits wide: ticket quantity.
REQ-010 The port resp_valid SHALL be an output, 1 bit wide: response present.
REQ-011 The port resp_ready SHALL be an input, 1 bit wide: consumer takes the response.
REQ-012 The port resp_ok SHALL be an output, 1 bit wide: request committed.
REQ-013 The port resp_err SHALL be an output, 2 bits wide: 00 none, 01 insufficient stock, 10 cancel overflow, 11 illegal (bad category, zero quantity, or BUY while closed).
REQ-014 The port avail SHALL be an output, NUM_CAT*CNT_W bits wide: packed per-category counts; category k occupies bits [k*CNT_W +: CNT_W].
REQ-015 The port sold_out SHALL be an output, NUM_CAT bits wide: bit k is 1 when count k == 0.
REQ-016 The port sold_total SHALL be an output, 16 bits wide: net tickets sold; saturates at 0xFFFF.

Function
REQ-017 The FSM SHALL have exactly three states: INIT, READY, RESP.
REQ-018 In INIT, the block SHALL load CAPACITY into category i on the i-th cycle after reset, taking NUM_CAT cycles, with req_ready=0; it SHALL then go to READY.
REQ-019 In READY, req_ready SHALL be 1; a request SHALL be accepted on a cycle with req_valid=1 and req_ready=1, and the FSM SHALL go to RESP on the next edge.
REQ-020 The decision and counter update SHALL occur at the accept edge; resp_valid SHALL assert on the following cycle (latency 1) with registered resp_ok/resp_err.
REQ-021 In RESP, req_ready SHALL be 0; resp_valid, resp_ok and resp_err SHALL hold stable until resp_ready=1, at which edge the FSM SHALL return to READY; throughput is at most one request per 2 cycles.
REQ-022 A BUY SHALL succeed iff sale_open=1, req_cat<NUM_CAT, req_qty!=0 and count>=req_qty; on success, count SHALL decrease by req_qty and sold_total SHALL increase by req_qty.
REQ-023 A BUY with qty>count SHALL fail with err 01 and SHALL leave the count unchanged; partial fills SHALL NOT occur.
REQ-024 A CANCEL SHALL succeed iff the category and quantity are legal and count+req_qty<=CAPACITY, regardless of sale_open; on success, count SHALL increase by req_qty and sold_total SHALL decrease by req_qty, flooring at 0; otherwise it SHALL fail with err 10.
REQ-025 Error priority SHALL be 11 > 01/10; a failed request SHALL modify no state.
REQ-026 Arithmetic SHALL be performed CNT_W+1 bits wide; counts SHALL never wrap below 0 or exceed CAPACITY.
REQ-027 sold_out and avail SHALL be combinational from the counters and SHALL be valid in every state, including INIT; counts not yet loaded SHALL read 0.
REQ-028 A change of sale_open during RESP SHALL NOT affect the pending response.
REQ-029 The elaboration check SHALL enforce CAPACITY < 2**CNT_W.

Reset
REQ-030 reset=1 at any clock edge, including mid-RESP, SHALL force state INIT, all counts 0, sold_total 0, resp_valid 0, resp_ok 0, resp_err 00 and req_ready 0; any pending response SHALL be discarded.
REQ-031 reset SHALL take precedence over every other input.

Structure
REQ-032 The package ticket_pkg SHALL hold the FSM state enum, the op encoding (OP_BUY, OP_CANCEL) and the error codes (ERR_NONE, ERR_STOCK, ERR_OVF, ERR_ILLEGAL).
REQ-033 One sub-module, ticket_counter, SHALL be instantiated NUM_CAT times; it holds one category count with load, sub-if-enough and add-if-fits operations and flag outputs.

Verification
REQ-034 Init: release reset, then sweep request attempts -> req_ready=0 for exactly 4 cycles; then avail={32,32,32,32}, sold_out=0000.
REQ-035 Drain: BUY cat0 qty7 repeated 4 times, then BUY cat0 qty4 -> counts 25,18,11,4,0; sold_out[0]=1; sold_total=32; a further BUY qty1 -> err 01, count stays 0.
REQ-036 Cancel bounds: cat1 at 32, CANCEL qty1 -> err 10; BUY qty5 then CANCEL qty5 -> 32, sold_total back to previous value.
REQ-037 Illegal: BUY with sale_open=0 -> err 11; qty0 -> err 11; CANCEL with sale_open=0 on sold stock -> ok.
REQ-038 Backpressure and reset: hold resp_ready=0 for 5 cycles -> response stable and req_ready=0; assert reset mid-RESP -> resp_valid=0 next cycle and re-init takes 4 cycles.
